// File: rtl/matrix_store_pkg.sv
// Shared bank-select encoding, default matrix side and element index helper
// for the matrix bank store.
package matrix_store_pkg;

  typedef enum logic [1:0] {
    SEL_Q   = 2'd0,
    SEL_R   = 2'd1,
    SEL_P   = 2'd2,
    SEL_INV = 2'd3
  } bank_sel_e;

  localparam int DIM_DEFAULT = 12;
  localparam int IDX_W       = 20;

  // Row-major element index; callers truncate to their address width.
  function automatic logic [IDX_W-1:0] elem_index(input logic [9:0]  row,
                                                  input logic [9:0]  col,
                                                  input logic [31:0] dim);
    logic [31:0] w_prod;
    w_prod = {22'd0, row} * dim + {22'd0, col};
    return w_prod[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/matrix_bank_ram.sv
// Simple dual-port bank: one write port, one registered read port.
// A same-cycle read and write of one address returns the old contents.
module matrix_bank_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 144,
  parameter int AW         = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Read register only loads on a request so the response holds under backpressure.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/matrix_bank_store.sv
// Three-bank DIMxDIM matrix store with written-flags and a valid/ready read port.
// Optional transposed mirror writes are enabled by defining MATRIX_SYM_MIRROR_EN.
module matrix_bank_store
  import matrix_store_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DIM        = DIM_DEFAULT
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic [DATA_WIDTH-1:0] matrix_data,
  input  logic [9:0]            matrix_row,
  input  logic [9:0]            matrix_col,
  input  logic                  matrix_wr_en,
  input  logic [1:0]            matrix_sel,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [1:0]            rd_sel,
  input  logic [9:0]            rd_row,
  input  logic [9:0]            rd_col,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  input  logic                  rsp_ready,
  output logic [2:0]            bank_full,
  input  logic [2:0]            bank_clr,
  output logic                  wr_err
);

  localparam int          NELEM = DIM * DIM;
  localparam int          AW    = (NELEM > 1) ? $clog2(NELEM) : 1;
  localparam logic [9:0]  DIM_L = 10'(DIM);
  localparam logic [31:0] DIM_U = 32'(DIM);

  logic                  w_wr_valid;
  logic [AW-1:0]         w_wr_idx;
  logic                  w_eff_en;
  logic [1:0]            w_eff_sel;
  logic [AW-1:0]         w_eff_idx;
  logic [DATA_WIDTH-1:0] w_eff_data;
  logic                  w_mir_clash;
  logic [NELEM-1:0]      w_set_mask;
  logic [NELEM-1:0]      w_flags_nxt [3];
  logic [NELEM-1:0]      r_flags     [3];
  logic [2:0]            w_full_nxt;
  logic [2:0]            r_bank_full;
  logic                  r_wr_err;
  logic                  w_rd_inrange;
  logic [AW-1:0]         w_rd_idx;
  logic                  w_rd_ready;
  logic                  w_rd_acc;
  logic                  w_rd_flag;
  logic                  r_rsp_valid;
  logic                  r_rsp_zero;
  logic                  r_rsp_err;
  logic [1:0]            r_rsp_sel;
  logic [DATA_WIDTH-1:0] w_ram_q [3];
  logic [DATA_WIDTH-1:0] w_rsp_data;

  assign w_wr_valid = matrix_wr_en && (matrix_sel != SEL_INV) &&
                      (matrix_row < DIM_L) && (matrix_col < DIM_L);
  assign w_wr_idx   = AW'(elem_index(matrix_row, matrix_col, DIM_U));

`ifdef MATRIX_SYM_MIRROR_EN
  logic                  r_mir_pend;
  logic [1:0]            r_mir_sel;
  logic [AW-1:0]         r_mir_idx;
  logic [DATA_WIDTH-1:0] r_mir_data;

  // Queue the transposed copy of every valid off-diagonal write.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_mir_pend <= 1'b0;
      r_mir_sel  <= 2'd0;
      r_mir_idx  <= '0;
      r_mir_data <= '0;
    end else begin
      r_mir_pend <= w_wr_valid && (matrix_row != matrix_col);
      r_mir_sel  <= matrix_sel;
      r_mir_idx  <= AW'(elem_index(matrix_col, matrix_row, DIM_U));
      r_mir_data <= matrix_data;
    end
  end

  // Any loader strobe in the mirror cycle wins and the mirror is dropped.
  always_comb begin
    w_mir_clash = r_mir_pend && matrix_wr_en;
    w_eff_en    = 1'b0;
    w_eff_sel   = matrix_sel;
    w_eff_idx   = w_wr_idx;
    w_eff_data  = matrix_data;
    if (w_wr_valid) begin
      w_eff_en = 1'b1;
    end else if (r_mir_pend && !matrix_wr_en) begin
      w_eff_en   = 1'b1;
      w_eff_sel  = r_mir_sel;
      w_eff_idx  = r_mir_idx;
      w_eff_data = r_mir_data;
    end else begin
      w_eff_en = 1'b0;
    end
  end
`else
  // Loader writes go straight to the banks.
  always_comb begin
    w_mir_clash = 1'b0;
    w_eff_en    = w_wr_valid;
    w_eff_sel   = matrix_sel;
    w_eff_idx   = w_wr_idx;
    w_eff_data  = matrix_data;
  end
`endif

  // Clear is applied before the same-cycle write so the written element stays flagged.
  always_comb begin
    w_set_mask = {{(NELEM-1){1'b0}}, 1'b1} << w_eff_idx;
    w_full_nxt = 3'd0;
    for (int b = 0; b < 3; b++) begin
      w_flags_nxt[b] = (bank_clr[b] ? {NELEM{1'b0}} : r_flags[b]) |
                       ((w_eff_en && (w_eff_sel == 2'(b))) ? w_set_mask : {NELEM{1'b0}});
      w_full_nxt[b]  = &w_flags_nxt[b];
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int b = 0; b < 3; b++) begin
        r_flags[b] <= '0;
      end
      r_bank_full <= 3'd0;
      r_wr_err    <= 1'b0;
    end else begin
      for (int b = 0; b < 3; b++) begin
        r_flags[b] <= w_flags_nxt[b];
      end
      r_bank_full <= w_full_nxt;
      r_wr_err    <= r_wr_err | (matrix_wr_en && !w_wr_valid) | w_mir_clash;
    end
  end

  assign w_rd_inrange = (rd_sel != SEL_INV) && (rd_row < DIM_L) && (rd_col < DIM_L);
  assign w_rd_idx     = w_rd_inrange ? AW'(elem_index(rd_row, rd_col, DIM_U)) : '0;
  assign w_rd_ready   = !r_rsp_valid || rsp_ready;
  assign w_rd_acc     = rd_valid && w_rd_ready;

  always_comb begin
    w_rd_flag = 1'b0;
    case (rd_sel)
      SEL_Q:   w_rd_flag = r_flags[0][w_rd_idx];
      SEL_R:   w_rd_flag = r_flags[1][w_rd_idx];
      SEL_P:   w_rd_flag = r_flags[2][w_rd_idx];
      default: w_rd_flag = 1'b0;
    endcase
  end

  // Response holds until consumed; unwritten or out-of-range reads answer zero.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rsp_valid <= 1'b0;
      r_rsp_zero  <= 1'b1;
      r_rsp_err   <= 1'b0;
      r_rsp_sel   <= 2'd0;
    end else if (w_rd_acc) begin
      r_rsp_valid <= 1'b1;
      r_rsp_zero  <= !(w_rd_inrange && w_rd_flag);
      r_rsp_err   <= !w_rd_inrange;
      r_rsp_sel   <= rd_sel;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_bank
    matrix_bank_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (NELEM),
      .AW        (AW)
    ) u_ram (
      .clk    (S_AXI_ACLK),
      .wr_en  (w_eff_en && (w_eff_sel == 2'(g))),
      .wr_addr(w_eff_idx),
      .wr_data(w_eff_data),
      .rd_en  (w_rd_acc),
      .rd_addr(w_rd_idx),
      .rd_data(w_ram_q[g])
    );
  end

  always_comb begin
    w_rsp_data = '0;
    if (r_rsp_zero) begin
      w_rsp_data = '0;
    end else begin
      case (r_rsp_sel)
        SEL_Q:   w_rsp_data = w_ram_q[0];
        SEL_R:   w_rsp_data = w_ram_q[1];
        SEL_P:   w_rsp_data = w_ram_q[2];
        default: w_rsp_data = '0;
      endcase
    end
  end

  assign rd_ready  = w_rd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = w_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign bank_full = r_bank_full;
  assign wr_err    = r_wr_err;

endmodule

// File: tb/tb_matrix_bank_store.sv
// Directed self-checking bench for matrix_bank_store (default 64-bit, 12x12).
// Mirror checks follow MATRIX_SYM_MIRROR_EN.
module tb_matrix_bank_store;

  logic        S_AXI_ACLK = 1'b0;
  logic        S_AXI_ARESETN;
  logic [63:0] matrix_data;
  logic [9:0]  matrix_row, matrix_col;
  logic        matrix_wr_en;
  logic [1:0]  matrix_sel;
  logic        rd_valid, rd_ready;
  logic [1:0]  rd_sel;
  logic [9:0]  rd_row, rd_col;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_err, rsp_ready;
  logic [2:0]  bank_full, bank_clr;
  logic        wr_err;

  int n_checks = 0;
  int n_errors = 0;

  matrix_bank_store #(.DATA_WIDTH(64), .DIM(12)) dut (
    .S_AXI_ACLK   (S_AXI_ACLK),
    .S_AXI_ARESETN(S_AXI_ARESETN),
    .matrix_data  (matrix_data),
    .matrix_row   (matrix_row),
    .matrix_col   (matrix_col),
    .matrix_wr_en (matrix_wr_en),
    .matrix_sel   (matrix_sel),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_sel       (rd_sel),
    .rd_row       (rd_row),
    .rd_col       (rd_col),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .rsp_ready    (rsp_ready),
    .bank_full    (bank_full),
    .bank_clr     (bank_clr),
    .wr_err       (wr_err)
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge S_AXI_ACLK);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [9:0] row, input logic [9:0] col,
                    input logic [63:0] data);
    matrix_wr_en = 1'b1;
    matrix_sel   = sel;
    matrix_row   = row;
    matrix_col   = col;
    matrix_data  = data;
    step();
    matrix_wr_en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] sel, input logic [9:0] row,
                    input logic [9:0] col, input logic [63:0] exp_data, input logic exp_err);
    check_value({tag, "_rdy"}, 64'(rd_ready), 64'd1);
    rd_valid = 1'b1;
    rd_sel   = sel;
    rd_row   = row;
    rd_col   = col;
    step();
    rd_valid = 1'b0;
    check_value({tag, "_vld"}, 64'(rsp_valid), 64'd1);
    check_value({tag, "_data"}, rsp_data, exp_data);
    check_value({tag, "_err"}, 64'(rsp_err), 64'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    S_AXI_ARESETN = 1'b0;
    matrix_data = 64'd0; matrix_row = 10'd0; matrix_col = 10'd0;
    matrix_wr_en = 1'b0; matrix_sel = 2'd0;
    rd_valid = 1'b0; rd_sel = 2'd0; rd_row = 10'd0; rd_col = 10'd0;
    rsp_ready = 1'b1; bank_clr = 3'd0;
    repeat (3) step();
    check_value("rst_vld",  64'(rsp_valid), 64'd0);
    check_value("rst_data", rsp_data, 64'd0);
    check_value("rst_err",  64'(rsp_err), 64'd0);
    check_value("rst_full", 64'(bank_full), 64'd0);
    check_value("rst_werr", 64'(wr_err), 64'd0);
    check_value("rst_rdy",  64'(rd_ready), 64'd1);
    @(negedge S_AXI_ACLK);
    S_AXI_ARESETN = 1'b1;
    step();

    // basic write / read, then response retires with rsp_ready=1
    wr(2'd0, 10'd2, 10'd5, 64'hDEAD_BEEF);
    rd("basic", 2'd0, 10'd2, 10'd5, 64'hDEAD_BEEF, 1'b0);
    step();
    check_value("retire_vld", 64'(rsp_valid), 64'd0);
    rd("unwritten", 2'd0, 10'd0, 10'd0, 64'd0, 1'b0);
    wr(2'd0, 10'd2, 10'd5, 64'h1234);
    rd("rewrite", 2'd0, 10'd2, 10'd5, 64'h1234, 1'b0);

    // fill bank R, then clear it
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < 12; c++) begin
        wr(2'd1, 10'(r), 10'(c), 64'(r * 256 + c));
        if (r == 11 && c == 10) check_value("full_early", 64'(bank_full), 64'd0);
      end
    end
    check_value("full_r", 64'(bank_full), 64'h2);
    rd("b1_last", 2'd1, 10'd11, 10'd11, 64'h0B0B, 1'b0);
    bank_clr = 3'b010;
    step();
    bank_clr = 3'b000;
    check_value("full_clr", 64'(bank_full), 64'd0);
    rd("b1_clr", 2'd1, 10'd11, 10'd11, 64'd0, 1'b0);

    // clear and write in one cycle: write survives
    wr(2'd1, 10'd3, 10'd3, 64'hC3);
    bank_clr = 3'b010;
    wr(2'd1, 10'd3, 10'd4, 64'hC4);
    bank_clr = 3'b000;
    rd("clrwr_new", 2'd1, 10'd3, 10'd4, 64'hC4, 1'b0);
    rd("clrwr_old", 2'd1, 10'd3, 10'd3, 64'd0, 1'b0);

    // invalid writes and out-of-range reads
    check_value("werr_pre", 64'(wr_err), 64'd0);
    wr(2'd3, 10'd0, 10'd0, 64'hFFFF);
    check_value("werr_sel", 64'(wr_err), 64'd1);
    wr(2'd0, 10'd1, 10'd17, 64'hBAD);
    rd("alias_keep", 2'd0, 10'd2, 10'd5, 64'h1234, 1'b0);
    wr(2'd0, 10'd12, 10'd0, 64'hBAD);
    rd("oob_row", 2'd0, 10'd12, 10'd0, 64'd0, 1'b1);
    rd("oob_sel", 2'd3, 10'd0, 10'd0, 64'd0, 1'b1);
    wr(2'd0, 10'd0, 10'd0, 64'h42);
    check_value("werr_sticky", 64'(wr_err), 64'd1);

    // read-before-write on the same element
    rd_valid = 1'b1; rd_sel = 2'd0; rd_row = 10'd2; rd_col = 10'd5;
    wr(2'd0, 10'd2, 10'd5, 64'h777);
    rd_valid = 1'b0;
    check_value("rbw_data", rsp_data, 64'h1234);
    rd("rbw_after", 2'd0, 10'd2, 10'd5, 64'h777, 1'b0);

    // backpressure then back-to-back
    wr(2'd0, 10'd0, 10'd1, 64'hA1);
    wr(2'd0, 10'd0, 10'd2, 64'hA2);
    rsp_ready = 1'b0;
    rd_valid = 1'b1; rd_sel = 2'd0; rd_row = 10'd0; rd_col = 10'd1;
    step();
    check_value("bp_vld",  64'(rsp_valid), 64'd1);
    check_value("bp_data", rsp_data, 64'hA1);
    check_value("bp_rdy",  64'(rd_ready), 64'd0);
    rd_col = 10'd2;
    step();
    check_value("bp_hold_vld",  64'(rsp_valid), 64'd1);
    check_value("bp_hold_data", rsp_data, 64'hA1);
    rsp_ready = 1'b1;
    #1;
    check_value("bp_rel_rdy", 64'(rd_ready), 64'd1);
    step();
    check_value("b2b0_vld",  64'(rsp_valid), 64'd1);
    check_value("b2b0_data", rsp_data, 64'hA2);
    rd_row = 10'd2; rd_col = 10'd5;
    step();
    check_value("b2b1_vld",  64'(rsp_valid), 64'd1);
    check_value("b2b1_data", rsp_data, 64'h777);
    rd_valid = 1'b0;
    step();
    check_value("b2b_idle", 64'(rsp_valid), 64'd0);

    // fill bank P so reset has a full flag to clear
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < 12; c++) begin
        wr(2'd2, 10'(r), 10'(c), 64'(r * 16 + c));
      end
    end
    check_value("full_p", 64'(bank_full), 64'h4);

    // reset with a pending response
    rsp_ready = 1'b0;
    rd_valid = 1'b1; rd_sel = 2'd0; rd_row = 10'd2; rd_col = 10'd5;
    step();
    rd_valid = 1'b0;
    check_value("mid_vld", 64'(rsp_valid), 64'd1);
    #2;
    S_AXI_ARESETN = 1'b0;
    #1;
    check_value("mid_rst_vld",  64'(rsp_valid), 64'd0);
    check_value("mid_rst_full", 64'(bank_full), 64'd0);
    check_value("mid_rst_werr", 64'(wr_err), 64'd0);
    check_value("mid_rst_data", rsp_data, 64'd0);
    rsp_ready = 1'b1;
    step();
    @(negedge S_AXI_ACLK);
    S_AXI_ARESETN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_value("post_rst_idle", 64'(rsp_valid), 64'd0);
    end
    rd("post_rst", 2'd0, 10'd2, 10'd5, 64'd0, 1'b0);

`ifdef MATRIX_SYM_MIRROR_EN
    wr(2'd2, 10'd1, 10'd3, 64'h55);
    step();
    check_value("mir_werr0", 64'(wr_err), 64'd0);
    rd("mir", 2'd2, 10'd3, 10'd1, 64'h55, 1'b0);
    wr(2'd2, 10'd4, 10'd6, 64'h66);
    wr(2'd2, 10'd0, 10'd0, 64'h11);
    check_value("mir_clash", 64'(wr_err), 64'd1);
    rd("mir_drop", 2'd2, 10'd6, 10'd4, 64'd0, 1'b0);
    rd("mir_keep", 2'd2, 10'd4, 10'd6, 64'h66, 1'b0);
`else
    wr(2'd2, 10'd1, 10'd3, 64'h55);
    step();
    rd("nomir", 2'd2, 10'd3, 10'd1, 64'd0, 1'b0);
    rd("nomir_keep", 2'd2, 10'd1, 10'd3, 64'h55, 1'b0);
    check_value("nomir_werr", 64'(wr_err), 64'd0);
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
